// File: rtl/clk_lim_sched.sv
// -----------------------------------------------------------------------------
// clk_lim_sched
// Steps a set of debug clock dividers through every combination of limit words
// drawn from a fixed 7-entry table (2^1, 2^2, 2^4, 2^6, 2^10, 2^12, 2^16).
// Each advance is made safe by draining the datapath first (req_quiet /
// quiet_ack), then updating the indices as an odometer, then holding the
// divider counters frozen (changing) for a settle period.
//
// Ports
//   i_clk      : single clock, all state in this domain
//   reset      : asynchronous, active-low
//   enable     : allows dwell-driven automatic advance
//   step       : one-cycle pulse requesting a manual advance (honoured in RUN only)
//   quiet_ack  : datapath reports no transfer in flight
//   req_quiet  : asks the datapath to stop starting transfers
//   changing   : freezes divider counters while high
//   lims       : limit word of divider k at [k*CLK_WDH +: CLK_WDH]
//   lim_idxs   : table index of divider k at [k*3 +: 3]
//   wrap       : one-cycle pulse when every index rolls over to zero
//   tmo_err    : sticky, set when a drain gave up waiting for quiet_ack
// -----------------------------------------------------------------------------
module clk_lim_sched #(
   parameter int CLK_WDH   = 17,
   parameter int NUM_CLKS  = 4,
   parameter int DWELL     = 250000,
   parameter int DRAIN_TMO = 1024,
   parameter int SETTLE    = 16
) (
   input  logic                         i_clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         step,
   input  logic                         quiet_ack,
   output logic                         req_quiet,
   output logic                         changing,
   output logic [NUM_CLKS*CLK_WDH-1:0]  lims,
   output logic [NUM_CLKS*3-1:0]        lim_idxs,
   output logic                         wrap,
   output logic                         tmo_err
);

   localparam int DW = (DWELL     > 1) ? $clog2(DWELL)     : 1;
   localparam int TW = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
   localparam int SW = (SETTLE    > 1) ? $clog2(SETTLE)    : 1;

   localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);
   localparam logic [TW-1:0] DRAIN_LAST  = TW'(DRAIN_TMO - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [DW-1:0] DWELL_ONE   = DW'(1);
   localparam logic [TW-1:0] DRAIN_ONE   = TW'(1);
   localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   // Limit word for a table index; zero-extended or truncated to CLK_WDH.
   function automatic logic [CLK_WDH-1:0] lim_of(input logic [2:0] idx);
      logic [31:0] v;
      case (idx)
         3'd0:    v = 32'h0000_0002;
         3'd1:    v = 32'h0000_0004;
         3'd2:    v = 32'h0000_0010;
         3'd3:    v = 32'h0000_0040;
         3'd4:    v = 32'h0000_0400;
         3'd5:    v = 32'h0000_1000;
         3'd6:    v = 32'h0001_0000;
         default: v = 32'h0000_0000;
      endcase
      return CLK_WDH'(v);
   endfunction

   state_e               state_q;
   logic [DW-1:0]        dwell_q;
   logic [TW-1:0]        drain_q;
   logic [SW-1:0]        settle_q;
   logic [2:0]           idx_q [NUM_CLKS];
   logic [2:0]           idx_d [NUM_CLKS];
   logic [CLK_WDH-1:0]   lim_q [NUM_CLKS];
   logic [CLK_WDH-1:0]   lim_d [NUM_CLKS];
   logic                 req_quiet_q;
   logic                 changing_q;
   logic                 wrap_q;
   logic                 wrap_d;
   logic                 tmo_err_q;
   logic                 carry_s;

   // Odometer increment of the index set and the matching limit words.
   always_comb begin
      carry_s = 1'b1;
      for (int k = 0; k < NUM_CLKS; k++) begin
         if (carry_s) begin
            if (idx_q[k] == 3'd6) begin
               idx_d[k] = 3'd0;
               carry_s  = 1'b1;
            end else begin
               idx_d[k] = idx_q[k] + 3'd1;
               carry_s  = 1'b0;
            end
         end else begin
            idx_d[k] = idx_q[k];
         end
         lim_d[k] = lim_of(idx_d[k]);
      end
      // Carry out of the last index means every index just rolled to zero.
      wrap_d = carry_s;
   end

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         dwell_q     <= '0;
         drain_q     <= '0;
         settle_q    <= '0;
         req_quiet_q <= 1'b0;
         changing_q  <= 1'b0;
         wrap_q      <= 1'b0;
         tmo_err_q   <= 1'b0;
         for (int k = 0; k < NUM_CLKS; k++) begin
            idx_q[k] <= 3'd0;
            lim_q[k] <= lim_of(3'd0);
         end
      end else begin
         wrap_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               // A step coinciding with the dwell terminal is one advance.
               if (step || (enable && (dwell_q == DWELL_LAST))) begin
                  state_q     <= ST_DRAIN;
                  dwell_q     <= '0;
                  drain_q     <= '0;
                  req_quiet_q <= 1'b1;
               end else if (enable) begin
                  dwell_q <= dwell_q + DWELL_ONE;
               end else begin
                  dwell_q <= dwell_q;
               end
            end
            ST_DRAIN: begin
               if (quiet_ack || (drain_q == DRAIN_LAST)) begin
                  state_q    <= ST_UPDATE;
                  changing_q <= 1'b1;
                  wrap_q     <= wrap_d;
                  for (int k = 0; k < NUM_CLKS; k++) begin
                     idx_q[k] <= idx_d[k];
                     lim_q[k] <= lim_d[k];
                  end
                  if (!quiet_ack) begin
                     tmo_err_q <= 1'b1;
                  end else begin
                     tmo_err_q <= tmo_err_q;
                  end
               end else begin
                  drain_q <= drain_q + DRAIN_ONE;
               end
            end
            ST_UPDATE: begin
               state_q  <= ST_SETTLE;
               settle_q <= '0;
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_q     <= ST_RUN;
                  changing_q  <= 1'b0;
                  req_quiet_q <= 1'b0;
               end else begin
                  settle_q <= settle_q + SETTLE_ONE;
               end
            end
            default: begin
               state_q     <= ST_RUN;
               changing_q  <= 1'b0;
               req_quiet_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CLKS; g++) begin : g_pack
      assign lims[g*CLK_WDH +: CLK_WDH] = lim_q[g];
      assign lim_idxs[g*3 +: 3]         = idx_q[g];
   end

   assign req_quiet = req_quiet_q;
   assign changing  = changing_q;
   assign wrap      = wrap_q;
   assign tmo_err   = tmo_err_q;

endmodule

// File: doc/clk_lim_sched.md
CLK_LIM_SCHED -- requirements
Module: clk_lim_sched

Interface
REQ-001 The module SHALL have parameter CLK_WDH, default 17: width of each divider limit word.
REQ-002 The module SHALL have parameter NUM_CLKS, default 4: number of debug clock dividers scheduled.
REQ-003 The module SHALL have parameter DWELL, default 250000: i_clk cycles spent per limit combination.
REQ-004 The module SHALL have parameter DRAIN_TMO, default 1024: maximum cycles to wait for quiet_ack.
REQ-005 The module SHALL have parameter SETTLE, default 16: cycles that changing stays high after a limit update.
REQ-006 The module SHALL have port i_clk, input, 1 bit: the single clock; all state is in this domain.
REQ-007 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The module SHALL have port enable, input, 1 bit: high allows automatic dwell-driven advance.
REQ-009 The module SHALL have port step, input, 1 bit: single-cycle pulse (debounced switch edge) requesting one manual advance.
REQ-010 The module SHALL have port quiet_ack, input, 1 bit: level from the datapath; high means no channel transfer is in flight.
REQ-011 The module SHALL have port req_quiet, output, 1 bit: asks the datapath to stop starting new transfers.
REQ-012 The module SHALL have port changing, output, 1 bit: freezes divider counters while high.
REQ-013 The module SHALL have port lims, output, NUM_CLKS*CLK_WDH bits: limit word of divider k at bits [k*CLK_WDH +: CLK_WDH].
REQ-014 The module SHALL have port lim_idxs, output, NUM_CLKS*3 bits: table index of divider k at bits [k*3 +: 3].
REQ-015 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when all indices roll over to zero.
REQ-016 The module SHALL have port tmo_err, output, 1 bit: sticky flag, set when a drain timed out.

Function
REQ-017 The limit table SHALL be the constant set idx0..6 = 1<<1, 1<<2, 1<<4, 1<<6, 1<<10, 1<<12, 1<<16 (the primes 2,3,5,7,11,13,17), zero-extended or truncated to CLK_WDH.
REQ-018 Each lims field SHALL equal the table entry at its lim_idxs field, registered and updated in the same cycle as the index.
REQ-019 The FSM SHALL have states RUN, DRAIN, UPDATE and SETTLE; the reset state SHALL be RUN.
REQ-020 In RUN, a dwell counter SHALL increment each cycle while enable=1 and hold while enable=0.
REQ-021 In RUN, the FSM SHALL go to DRAIN when the dwell counter reaches DWELL-1 or when step=1, and SHALL clear the dwell counter on that transition.
REQ-022 When the dwell terminal and step occur in the same cycle, exactly one advance SHALL result.
REQ-023 In DRAIN, req_quiet SHALL be 1; the FSM SHALL go to UPDATE on the first cycle with quiet_ack=1, or after DRAIN_TMO cycles, in which case it SHALL set tmo_err.
REQ-024 UPDATE SHALL last one cycle with changing=1 and SHALL advance the indices as an odometer: idx0 increments; an index at 6 wraps to 0 and carries into the next index.
REQ-025 A carry out of idx[NUM_CLKS-1] SHALL pulse wrap for the UPDATE cycle.
REQ-026 SETTLE SHALL hold changing=1 and req_quiet=1 for SETTLE cycles and then return to RUN, where both outputs are 0.
REQ-027 step pulses received outside RUN SHALL be ignored, not queued.
REQ-028 A quiet_ack that is already high on DRAIN entry SHALL give a DRAIN stay of exactly one cycle.

Reset
REQ-029 When reset=0, the module SHALL immediately force: state RUN, counters 0, all indices 0, lims = all fields 2, req_quiet=0, changing=0, wrap=0, tmo_err=0.
REQ-030 An assertion of reset in any state, including mid-UPDATE, SHALL abort the sequence with no partial index update surviving.
REQ-031 The module SHALL restart counting on the first clock edge after reset deasserts.

Verification
REQ-032 Auto advance: DWELL=8, enable=1, quiet_ack=1 -> req_quiet rises on cycle 8 after reset; idx0 goes 0->1 and lims field0 becomes 4; changing stays high for 1+SETTLE cycles.
REQ-033 Odometer: 7 advances starting from all indices 0 -> idx0=0, idx1=1, lims field1=4, wrap=0; with NUM_CLKS=2, the 49th advance -> all indices 0 and one wrap pulse.
REQ-034 Drain handshake: quiet_ack=0 held for 5 cycles in DRAIN, then 1 -> UPDATE on the cycle after ack, tmo_err=0; quiet_ack held 0 with DRAIN_TMO=4 -> UPDATE after 4 cycles and tmo_err=1, which stays set.
REQ-035 Manual and collision: enable=0 and a step pulse -> exactly one advance; step coincident with dwell terminal -> exactly one advance; step during SETTLE -> no extra advance.
REQ-036 Reset mid-operation: reset=0 asserted in UPDATE or SETTLE -> all outputs equal their reset values asynchronously, before the next clock edge.
